imem_fetch_resp: RTL and testbench
==================================

Name: imem_fetch_resp

Overview:
- Responder side of the PC fetch interface: instruction memory that takes the PC and returns the instruction to the IM_ID pipeline register.
- Also serves LWI (movc) constant reads at dst_EX_DM, and provides a host program-load port with a valid/ready handshake.
- A single-port array is shared by fetch, LWI and load, under a small FSM.

Parameters:
ADDR_W, 12, array address width; only the low ADDR_W bits of all 16-bit addresses are used.
DEPTH, 4096, number of 16-bit words; must be at most 2**ADDR_W.
NOP_INSTR, 16'h0000, instruction injected on flush, during load, and at reset.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pc  in  16  fetch address from the PC register
stall_IM_ID  in  1  pipe stall; hold the IM_ID instruction
flush_IM_ID  in  1  flow change taken; squash the fetched instruction
LWI_instr_EX_DM  in  1  LWI in DM stage; read the constant at dst_EX_DM
dst_EX_DM  in  16  LWI read address
instr_IM_ID  out  16  registered instruction to the ID stage
lwi_data  out  16  registered LWI read data
lwi_vld  out  1  one-cycle pulse: lwi_data updated
lwi_err  out  1  sticky: LWI arrived without a stall
ld_en  in  1  host requests program-load mode
ld_vld  in  1  host load word valid
ld_data  in  16  host load word
ld_rdy  out  1  block accepts a load word
ld_done  out  1  one-cycle pulse on load-mode exit
ld_cnt  out  ADDR_W+1  words written in the last or current load

Behaviour:
- Reset (async): state=RUN; instr_IM_ID=NOP_INSTR; lwi_data=0; lwi_vld=0; lwi_err=0; ld_rdy=0; ld_done=0; ld_cnt=0. Array contents are not reset.
- FSM states: RUN, LOAD, FULL.
- RUN -> LOAD when ld_en=1 is sampled. On entry: ld_cnt<=0, load address<=0.
- LOAD -> FULL when the write at address DEPTH-1 completes.
- LOAD or FULL -> RUN when ld_en=0 is sampled. ld_done pulses high for the cycle after exit. ld_cnt holds its value.
- ld_rdy=1 only in LOAD; it is registered and changes with the state.
- Write handshake: in LOAD, ld_vld&&ld_rdy writes mem[load address]<=ld_data, then load address+1 and ld_cnt+1. ld_vld with ld_rdy=0 is ignored with no side effects.
- In LOAD and FULL: instr_IM_ID<=NOP_INSTR each cycle; LWI_instr_EX_DM is ignored; lwi_vld=0.
- RUN cycle priority, highest first:
  - stall_IM_ID=1 and LWI_instr_EX_DM=1: the array port reads mem[dst_EX_DM]; lwi_data updates at the next edge and lwi_vld=1 for that one cycle; instr_IM_ID holds.
  - stall_IM_ID=1 and no LWI: instr_IM_ID holds. This includes stall with flush: stall wins and the flush is not remembered.
  - stall_IM_ID=0 and flush_IM_ID=1: instr_IM_ID<=NOP_INSTR.
  - stall_IM_ID=0 and LWI_instr_EX_DM=1: protocol violation. LWI is served as above, instr_IM_ID<=NOP_INSTR, and lwi_err<=1 (sticky until reset).
  - Otherwise: instr_IM_ID<=mem[pc], giving a 1-cycle fetch latency.
- Addresses (pc, dst_EX_DM) use bits [ADDR_W-1:0]; upper bits are ignored. There is no bounds error.
- The load address wraps only via FULL; it never writes past DEPTH-1.
- Reads of never-written locations return X in simulation; benches must load first.
- Reset asserted mid-load abandons the load: state RUN, ld_rdy=0, no ld_done pulse. Words already written remain.
- ld_en held low for a single cycle is sufficient to exit; a one-cycle ld_en high is sufficient to enter.

Test Plan:
1. After reset, ld_en=1; write A000,A001,A002,A003 with one idle ld_vld cycle between words 2 and 3; drop ld_en -> ld_cnt=4, ld_done high exactly one cycle, ld_rdy=0, instr_IM_ID=NOP_INSTR throughout.
2. RUN, pc=0,1,2,3 on consecutive cycles -> instr_IM_ID=A000,A001,A002,A003 each one cycle later.
3. pc=2 with stall_IM_ID=1 for 2 cycles -> instr_IM_ID stays at the pre-stall value; once stall drops it updates from the current pc. Also: flush_IM_ID=1 with stall=0 -> instr_IM_ID=NOP_INSTR for one cycle, then A00x resumes.
4. stall=1, LWI_instr_EX_DM=1, dst_EX_DM=16'hF003 (upper bits ignored) -> next cycle lwi_data=A003, lwi_vld pulses one cycle, instr_IM_ID unchanged, lwi_err=0. Repeat with stall=0 -> lwi_err=1 and stays 1; instr_IM_ID=NOP_INSTR.
5. DEPTH=8: ld_en=1, 9 back-to-back ld_vld words -> ld_rdy falls after the 8th write, 9th word is ignored, ld_cnt=8; on ld_en=0, ld_done pulses.
6. Assert rst_n=0 after 3 load writes -> state RUN, ld_rdy=0, no ld_done; then fetch addresses 0-2 -> the 3 loaded words.

Source files
------------

// File: rtl/imem_fetch_resp.sv
// imem_fetch_resp: instruction memory serving fetch, LWI constant reads and host program load
module imem_fetch_resp #(
  parameter int          ADDR_W    = 12,
  parameter int          DEPTH     = 4096,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       pc,
  input  logic              stall_IM_ID,
  input  logic              flush_IM_ID,
  input  logic              LWI_instr_EX_DM,
  input  logic [15:0]       dst_EX_DM,
  output logic [15:0]       instr_IM_ID,
  output logic [15:0]       lwi_data,
  output logic              lwi_vld,
  output logic              lwi_err,
  input  logic              ld_en,
  input  logic              ld_vld,
  input  logic [15:0]       ld_data,
  output logic              ld_rdy,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_cnt
);
  typedef enum logic [1:0] {RUN, LOAD, FULL} state_t;
  state_t state, state_nxt;
  logic [15:0] mem [DEPTH];
  logic [ADDR_W-1:0] ld_addr, raddr;
  logic [15:0] rdata, instr_nxt;
  logic run, wr, lwi_rd;
  always_comb begin
    run = state == RUN && !ld_en;
    wr = state == LOAD && ld_vld && ld_rdy;
    // flush outranks an unstalled LWI, so such an LWI is dropped without error
    lwi_rd = run && LWI_instr_EX_DM && (stall_IM_ID || !flush_IM_ID);
    raddr = lwi_rd ? dst_EX_DM[ADDR_W-1:0] : pc[ADDR_W-1:0];
    rdata = mem[raddr];
    state_nxt = state == RUN ? (ld_en ? LOAD : RUN) :
                !ld_en ? RUN :
                (wr && ld_addr == ADDR_W'(DEPTH - 1)) ? FULL : state;
    instr_nxt = !run ? NOP_INSTR :
                stall_IM_ID ? instr_IM_ID :
                (flush_IM_ID || LWI_instr_EX_DM) ? NOP_INSTR : rdata;
  end
  always_ff @(posedge clk)
    if (wr) mem[ld_addr] <= ld_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      instr_IM_ID <= NOP_INSTR;
      lwi_data <= '0;
      lwi_vld <= 1'b0;
      lwi_err <= 1'b0;
      ld_rdy <= 1'b0;
      ld_done <= 1'b0;
      ld_cnt <= '0;
      ld_addr <= '0;
    end else begin
      state <= state_nxt;
      instr_IM_ID <= instr_nxt;
      lwi_data <= lwi_rd ? rdata : lwi_data;
      lwi_vld <= lwi_rd;
      lwi_err <= lwi_err | (lwi_rd && !stall_IM_ID);
      ld_rdy <= state_nxt == LOAD;
      ld_done <= state != RUN && state_nxt == RUN;
      ld_cnt <= (state == RUN && ld_en) ? '0 : wr ? ld_cnt + (ADDR_W+1)'(1) : ld_cnt;
      ld_addr <= (state == RUN && ld_en) ? '0 : wr ? ld_addr + ADDR_W'(1) : ld_addr;
    end
endmodule

// File: tb/tb_imem_fetch_resp.sv
// tb_imem_fetch_resp: directed and random checks of imem_fetch_resp against a rule-level model
module tb_imem_fetch_resp;
  localparam int AW = 3;
  localparam int D = 8;
  localparam logic [15:0] NOP = 16'h0000;
  logic clk = 0, rst_n = 0;
  logic [15:0] pc = 0, dst = 0, ld_data = 0;
  logic stall = 0, flush = 0, lwi = 0, ld_en = 0, ld_vld = 0;
  logic [15:0] instr, lwi_data;
  logic lwi_vld, lwi_err, ld_rdy, ld_done;
  logic [AW:0] ld_cnt;
  int n_chk = 0, n_fail = 0;
  logic [15:0] mdl [D];
  logic [15:0] e_instr, e_ld;
  logic e_vld, e_err, e_rdy, e_done, in_load;
  int e_cnt;

  imem_fetch_resp #(.ADDR_W(AW), .DEPTH(D), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .stall_IM_ID(stall), .flush_IM_ID(flush),
    .LWI_instr_EX_DM(lwi), .dst_EX_DM(dst), .instr_IM_ID(instr), .lwi_data(lwi_data),
    .lwi_vld(lwi_vld), .lwi_err(lwi_err), .ld_en(ld_en), .ld_vld(ld_vld),
    .ld_data(ld_data), .ld_rdy(ld_rdy), .ld_done(ld_done), .ld_cnt(ld_cnt));

  always #5 clk = ~clk;

  task automatic one(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check();
    one("instr", instr, e_instr);
    one("lwi_data", lwi_data, e_ld);
    one("lwi_vld", 16'(lwi_vld), 16'(e_vld));
    one("lwi_err", 16'(lwi_err), 16'(e_err));
    one("ld_rdy", 16'(ld_rdy), 16'(e_rdy));
    one("ld_done", 16'(ld_done), 16'(e_done));
    one("ld_cnt", 16'(ld_cnt), 16'(e_cnt));
  endtask

  task automatic model_reset();
    e_instr = NOP; e_ld = 0; e_vld = 0; e_err = 0; e_rdy = 0; e_done = 0;
    e_cnt = 0; in_load = 0;
  endtask

  task automatic tick();
    e_vld = 0; e_done = 0;
    if (!in_load) begin
      if (ld_en) begin
        in_load = 1; e_cnt = 0; e_instr = NOP;
      end else if (stall) begin
        if (lwi) begin e_ld = mdl[dst[AW-1:0]]; e_vld = 1; end
      end else if (flush) e_instr = NOP;
      else if (lwi) begin
        e_ld = mdl[dst[AW-1:0]]; e_vld = 1; e_err = 1; e_instr = NOP;
      end else e_instr = mdl[pc[AW-1:0]];
    end else begin
      e_instr = NOP;
      if (ld_vld && e_rdy) begin mdl[e_cnt] = ld_data; e_cnt++; end
      if (!ld_en) begin in_load = 0; e_done = 1; end
    end
    e_rdy = in_load && e_cnt < D;
  endtask

  task automatic cyc(input logic s, f, l, input logic [15:0] p, d,
                     input logic e, v, input logic [15:0] w);
    stall = s; flush = f; lwi = l; pc = p; dst = d; ld_en = e; ld_vld = v; ld_data = w;
    @(posedge clk);
    tick();
    @(negedge clk);
    check();
  endtask

  task automatic run_pc(input logic [15:0] p);
    cyc(0, 0, 0, p, 0, 0, 0, 0);
  endtask

  task automatic load(input logic v, input logic [15:0] w);
    cyc(0, 0, 0, 0, 0, 1, v, w);
  endtask

  initial begin
    model_reset();
    #12;
    check();
    @(negedge clk);
    rst_n = 1;
    load(0, 0);
    load(1, 16'hA000);
    load(1, 16'hA001);
    load(1, 16'hA002);
    load(0, 16'h5555);
    load(1, 16'hA003);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) run_pc(16'(i));
    cyc(1, 0, 0, 2, 0, 0, 0, 0);
    cyc(1, 1, 0, 2, 0, 0, 0, 0);
    run_pc(2);
    cyc(0, 1, 0, 1, 0, 0, 0, 0);
    run_pc(1);
    cyc(1, 0, 1, 0, 16'hF003, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 16'h0002, 0, 0, 0);
    cyc(0, 0, 1, 0, 16'h0001, 0, 0, 0);
    run_pc(3);
    load(0, 0);
    for (int i = 0; i < 9; i++) load(1, 16'hB000 + 16'(i));
    load(1, 16'hBEEF);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) run_pc(16'(i) | 16'hFF00);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 40) == 0) begin
        for (int j = 0; j < 12; j++) load(1'($urandom), 16'($urandom));
      end
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 5) == 0), 16'($urandom), 16'($urandom), 0, 1'($urandom), 16'($urandom));
    end
    load(0, 0);
    for (int i = 0; i < 3; i++) load(1, 16'hC000 + 16'(i));
    rst_n = 0;
    model_reset();
    #1;
    check();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) run_pc(16'(i));
    run_pc(0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
